// File: rtl/pmp_region_programmer.sv
// Turns a byte-address region request into a sequence of PMP CSR writes.
// Picks NA4, NAPOT or TOR encoding and uses one or two entries. Rejects
// malformed, out-of-range and locked-entry requests without writing anything.
module pmp_region_programmer #(
   parameter int NUM_ENTRIES = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [31:0]            req_base,
   input  logic [31:0]            req_top,
   input  logic [2:0]             req_perm,
   input  logic                   req_lock,
   input  logic [3:0]             req_entry,
   output logic                   csr_we,
   output logic                   csr_sel,
   output logic [3:0]             csr_idx,
   output logic [31:0]            csr_wdata,
   input  logic                   csr_ack,
   input  logic [NUM_ENTRIES-1:0] lock_status,
   output logic                   resp_valid,
   output logic                   resp_err,
   output logic [1:0]             resp_mode,
   output logic [1:0]             resp_entries
);

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_TOR   = 2'd1;
   localparam logic [1:0] MODE_NA4   = 2'd2;
   localparam logic [1:0] MODE_NAPOT = 2'd3;
   localparam logic [5:0] LP_NUM     = 6'(NUM_ENTRIES);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CLASSIFY, ST_WR_ADDR0, ST_WR_CFG0, ST_WR_ADDR1, ST_WR_CFG1, ST_RESP
   } state_t;

   state_t      r_state, w_state_nxt;

   logic [31:0] r_base, r_top;
   logic [2:0]  r_perm;
   logic        r_lock;
   logic [3:0]  r_entry;

   logic        r_two;
   logic [1:0]  r_mode;
   logic [31:0] r_addr0, r_addr1;
   logic [7:0]  r_cfg0, r_cfg1;

   logic        r_resp_err;
   logic [1:0]  r_resp_mode;
   logic [1:0]  r_resp_entries;

   logic [31:0] w_size, w_size_m1, w_lock_ext;
   logic        w_pow2, w_na4, w_napot, w_tor2, w_err;
   logic [4:0]  w_idx0, w_idx1, w_last;
   logic [1:0]  w_mode;
   logic [31:0] w_addr0, w_addr1;
   logic [7:0]  w_cfg_final, w_cfg0;

   // Region classification and error detection on the latched request.
   always_comb begin
      w_size      = r_top - r_base;
      w_size_m1   = w_size - 32'd1;
      w_pow2      = (w_size != 32'd0) && ((w_size & w_size_m1) == 32'd0);
      w_na4       = (w_size == 32'd4);
      w_napot     = w_pow2 && (w_size >= 32'd8) && ((r_base & w_size_m1) == 32'd0);
      w_tor2      = !w_na4 && !w_napot && (r_base != 32'd0);
      w_idx0      = {1'b0, r_entry};
      w_idx1      = w_idx0 + 5'd1;
      w_last      = w_tor2 ? w_idx1 : w_idx0;
      // Zero-extended so an out-of-range index reads as unlocked; range is checked separately.
      w_lock_ext  = 32'(lock_status);
      w_err       = (r_top <= r_base) || (|r_base[1:0]) || (|r_top[1:0]) ||
                    ({1'b0, w_last} >= LP_NUM) || w_lock_ext[w_idx0] ||
                    (w_tor2 && w_lock_ext[w_idx1]);
      w_mode      = MODE_TOR;
      w_addr0     = {2'b00, r_top[31:2]};
      w_addr1     = {2'b00, r_top[31:2]};
      if (w_na4) begin
         w_mode  = MODE_NA4;
         w_addr0 = {2'b00, r_base[31:2]};
      end else if (w_napot) begin
         w_mode  = MODE_NAPOT;
         w_addr0 = (r_base | ((w_size >> 1) - 32'd1)) >> 2;
      end else if (w_tor2) begin
         w_addr0 = {2'b00, r_base[31:2]};
      end
      // Only the final entry carries permissions and lock; the OFF base entry stays all-zero.
      w_cfg_final = {r_lock, 2'b00, w_mode, r_perm};
      w_cfg0      = w_tor2 ? {2'b00, MODE_OFF, 4'b0000} : w_cfg_final;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; each write state advances only on its ack.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:     if (req_valid) w_state_nxt = ST_CLASSIFY;
         ST_CLASSIFY: w_state_nxt = w_err ? ST_RESP : ST_WR_ADDR0;
         ST_WR_ADDR0: if (csr_ack) w_state_nxt = ST_WR_CFG0;
         ST_WR_CFG0:  if (csr_ack) w_state_nxt = r_two ? ST_WR_ADDR1 : ST_RESP;
         ST_WR_ADDR1: if (csr_ack) w_state_nxt = ST_WR_CFG1;
         ST_WR_CFG1:  if (csr_ack) w_state_nxt = ST_RESP;
         ST_RESP:     w_state_nxt = ST_IDLE;
         default:     w_state_nxt = ST_IDLE;
      endcase
   end

   // Request capture and classification results; pure data, no reset needed.
   always_ff @(posedge clk) begin
      if (r_state == ST_IDLE && req_valid) begin
         r_base  <= req_base;
         r_top   <= req_top;
         r_perm  <= req_perm;
         r_lock  <= req_lock;
         r_entry <= req_entry;
      end
      if (r_state == ST_CLASSIFY) begin
         r_two   <= w_tor2;
         r_mode  <= w_mode;
         r_addr0 <= w_addr0;
         r_addr1 <= w_addr1;
         r_cfg0  <= w_cfg0;
         r_cfg1  <= w_cfg_final;
      end
   end

   // Response fields update only on entry to RESP and hold between requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp_err     <= 1'b0;
         r_resp_mode    <= MODE_OFF;
         r_resp_entries <= 2'd0;
      end else if (w_state_nxt == ST_RESP && r_state != ST_RESP) begin
         if (r_state == ST_CLASSIFY) begin
            r_resp_err     <= 1'b1;
            r_resp_mode    <= MODE_OFF;
            r_resp_entries <= 2'd0;
         end else begin
            r_resp_err     <= 1'b0;
            r_resp_mode    <= r_mode;
            r_resp_entries <= r_two ? 2'd2 : 2'd1;
         end
      end
   end

   // CSR write port driven from the current write state; idle value is all-zero.
   always_comb begin
      csr_we    = 1'b0;
      csr_sel   = 1'b0;
      csr_idx   = 4'd0;
      csr_wdata = 32'd0;
      case (r_state)
         ST_WR_ADDR0: begin
            csr_we    = 1'b1;
            csr_idx   = r_entry;
            csr_wdata = r_addr0;
         end
         ST_WR_CFG0: begin
            csr_we    = 1'b1;
            csr_sel   = 1'b1;
            csr_idx   = r_entry;
            csr_wdata = {24'd0, r_cfg0};
         end
         ST_WR_ADDR1: begin
            csr_we    = 1'b1;
            csr_idx   = r_entry + 4'd1;
            csr_wdata = r_addr1;
         end
         ST_WR_CFG1: begin
            csr_we    = 1'b1;
            csr_sel   = 1'b1;
            csr_idx   = r_entry + 4'd1;
            csr_wdata = {24'd0, r_cfg1};
         end
         default: ;
      endcase
   end

   assign req_ready    = (r_state == ST_IDLE);
   assign resp_valid   = (r_state == ST_RESP);
   assign resp_err     = r_resp_err;
   assign resp_mode    = r_resp_mode;
   assign resp_entries = r_resp_entries;

endmodule
